serial_word_tx: RTL
===================

// Module: serial_word_tx
// PURPOSE
// Parallel-in, serial-out word transmitter. Sources the LSB-first 1-bit stream consumed by
// our serial bit-stream FSMs (e.g. serial two's-complement unit). Accepts a WIDTH-bit word on
// a valid/ready handshake, then emits it one bit per clock. It marks the first bit with
// ser_sof, so the downstream FSM can re-initialise per word. It marks the last bit with ser_eof.
// PARAMETERS
// WIDTH  8  bits per word; legal range 2..32
// GAP    1  idle cycles inserted after each word (0 = back-to-back words allowed)
// PORTS
// clk        in   1      single clock, all state updates on posedge
// rst_n      in   1      asynchronous, active-low reset
// in_data    in   WIDTH  parallel word to transmit
// in_valid   in   1      in_data is valid
// in_ready   out  1      block can accept a word (registered)
// ser_out    out  1      serial data bit, LSB first
// ser_valid  out  1      ser_out carries a word bit this cycle
// ser_sof    out  1      first bit (bit 0) of a word is on ser_out
// ser_eof    out  1      last bit (bit WIDTH-1) of a word is on ser_out
// busy       out  1      word in flight or in gap (state != IDLE)
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; shift reg, bit/gap counters = 0.
//   All outputs = 0, including in_ready. First posedge after release: in_ready <= 1.
// - Accept = in_valid && in_ready, sampled at posedge. in_data is captured at that edge.
//   in_data is don't-care at all other times. in_valid may be held with no word taken while in_ready=0.
// - States: IDLE, SHIFT, GAP. All outputs are registered.
// - IDLE: in_ready=1, ser_valid=ser_sof=ser_eof=ser_out=0.
//   On accept: state->SHIFT, ser_out<=in_data[0], ser_valid<=1, ser_sof<=1, bit_cnt<=0,
//   in_ready<=0. Latency is 1 cycle: bit 0 is visible in the cycle after the accept edge.
// - SHIFT: each edge bit_cnt++ and the next bit drives ser_out. ser_sof=1 only when bit_cnt=0.
//   ser_eof=1 only when bit_cnt=WIDTH-1. ser_valid=1 throughout.
//   A word occupies exactly WIDTH consecutive ser_valid cycles. No stalls, no backpressure.
// - Leaving the eof cycle, GAP>0: state->GAP, gap_cnt<=0. ser_valid/ser_sof/ser_eof/ser_out all 0.
// - GAP: exactly GAP cycles with ser_valid=0. In_ready<=1 on the last GAP edge, so in_ready is
//   high in the cycle after the gap. State then ->IDLE.
// - GAP=0: in_ready<=1 at the edge that brings up the eof bit, so in_ready=1 during the eof cycle.
//   * Accept in the eof cycle: next cycle shows bit 0 of the new word with ser_sof=1.
//     This gives a continuous stream with no idle cycles.
//   * No accept in the eof cycle: ->IDLE, ser_valid=0.
// - in_valid during SHIFT/GAP (in_ready=0) is ignored. The word is not captured or queued.
// - Reset asserted mid-word: output stops immediately with all outputs 0. The partial word is
//   discarded. No eof is produced for it. After release the block restarts from IDLE.
// - bit_cnt width = $clog2(WIDTH). gap_cnt width = $clog2(GAP+1). Counters never wrap
//   mid-word; they are reloaded on each state entry.
// TESTING (WIDTH=8 unless stated)
// 1 Reset: rst_n=0 mid-simulation, no clock edge -> all outputs 0 at once. Release ->
//   in_ready=1 after first posedge.
// 2 Single word, GAP=1: accept 8'hB4 -> ser_out = 0,0,1,0,1,1,0,1 on 8 consecutive
//   ser_valid cycles starting 1 cycle after accept. sof on bit 0, eof on bit 7.
//   Then 1 idle cycle, then in_ready=1.
// 3 Back-to-back, GAP=0: in_valid held high with 8'hFF then 8'h01 -> 16 continuous ser_valid cycles
//   (1 x8, then 1,0 x7). ser_sof on cycles 0 and 8. ser_eof on cycles 7 and 15.
// 4 Busy drop: in_valid=1 with 8'hAA accepted, then 8'h55 offered during SHIFT -> 8'h55 is not sent.
//   Only 8'hAA bits appear until it is re-offered while in_ready=1.
// 5 Mid-word reset: accept 8'hC3, assert rst_n=0 after 3 bits -> outputs 0 immediately.
//   After release, accepting 8'h0F gives a clean word with sof and no residual bits.
// 6 Downstream check: feed ser_out into the serial two's-complement unit, using ser_sof as its
//   per-word reset. For 8'h06, the collected result == 8'hFA.

Source files
------------

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-in, LSB-first serial-out word transmitter with sof/eof framing
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic             ser_eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  // Bits still to be sent after the one currently on ser_out, next bit at [0]
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           ser_out_d, ser_valid_d, ser_sof_d, ser_eof_d, in_ready_d, busy_d;

  logic accept;
  logic at_eof;

  assign accept = in_valid && in_ready;
  assign at_eof = (bit_cnt_q == LAST_BIT);

  // State, datapath and registered outputs; async reset clears everything including in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      ser_eof   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      ser_sof   <= ser_sof_d;
      ser_eof   <= ser_eof_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state: with GAP=0 an accept in the eof cycle chains straight into the next word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (at_eof) begin
          if (GAP > 0)     state_d = S_GAP;
          else if (accept) state_d = S_SHIFT;
          else             state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_sof_d   = 1'b0;
    ser_eof_d   = 1'b0;
    in_ready_d  = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          shreg_d     = in_data[WIDTH-1:1];
          bit_cnt_d   = '0;
          ser_out_d   = in_data[0];
          ser_valid_d = 1'b1;
          ser_sof_d   = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!at_eof) begin
          shreg_d     = shreg_q >> 1;
          bit_cnt_d   = bit_cnt_q + CW'(1);
          ser_out_d   = shreg_q[0];
          ser_valid_d = 1'b1;
          ser_eof_d   = (bit_cnt_q == PRE_LAST);
          // Without a gap, the eof cycle already offers a slot for the next word
          in_ready_d  = (GAP == 0) && (bit_cnt_q == PRE_LAST);
        end else if (GAP > 0) begin
          gap_cnt_d = '0;
        end else if (accept) begin
          shreg_d     = in_data[WIDTH-1:1];
          bit_cnt_d   = '0;
          ser_out_d   = in_data[0];
          ser_valid_d = 1'b1;
          ser_sof_d   = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) in_ready_d = 1'b1;
        else                       gap_cnt_d  = gap_cnt_q + GW'(1);
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

endmodule
